lsu_ctrl: RTL
=============

# lsu_ctrl

Load/store sequencer between the CPU execute stage and `mem_ctrl`. It accepts one load/store request at a time over a valid/ready handshake and drives `mem_ctrl`'s address, write-data and mode inputs for the correct number of cycles, including the two-cycle hold that 32-bit accesses need. It captures the read data, sign- or zero-extends it, and returns a single-cycle response with optional misalignment error.

## Interface
- `MEM_DEPTH`, 2**12: memory size in halfwords. Must match `mem_ctrl`.
- `ADDR_WIDTH`, $clog2(MEM_DEPTH*2): byte-address width. Localparam.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `i_req_valid` in 1: request valid.
- `o_req_ready` out 1: request accepted when `valid & ready` at a rising edge.
- `i_req_op` in 3: 000 LB, 001 LH, 010 LW, 011 SB, 100 LBU, 101 LHU, 110 SH, 111 SW.
- `i_req_addr` in ADDR_WIDTH: byte address.
- `i_req_wdata` in 32: store data, right-aligned.
- `o_rsp_valid` out 1: one-cycle response pulse.
- `o_rsp_rdata` out 32: extended load data. Zero for stores.
- `o_rsp_err` out 1: misaligned request. Valid with `o_rsp_valid`.
- `o_cpu_addr` out ADDR_WIDTH: to `mem_ctrl` `i_cpu_addr`.
- `o_cpu_data` out 32: to `mem_ctrl` `i_cpu_data`.
- `o_wr_mode`, `o_rd_mode` out 2: to `mem_ctrl`. Encoding: 0 NONE, 1 16-bit, 2 32-bit, 3 8-bit.
- `i_cpu_data` in 32: from `mem_ctrl` `o_cpu_data`.

## Operation
- States: IDLE, ACC1, ACC2, CAPT, RESP.
- Reset state:
  - state = IDLE.
  - All outputs 0: modes = NONE, `o_req_ready`=0 while `rst` is asserted.
  - After reset, `o_req_ready`=1 exactly when state = IDLE.
- Accept in IDLE:
  - Register op, addr and wdata.
  - Misaligned request (LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0) goes to RESP with err=1. No memory access is made.
  - Otherwise go to ACC1.
- ACC1:
  - `o_cpu_addr`=addr, `o_cpu_data`=wdata.
  - Mode = 8/16/32 according to op, on `o_wr_mode` for stores or `o_rd_mode` for loads.
  - Next state: 32-bit → ACC2; other load → CAPT; other store → RESP.
- ACC2 (LW/SW only):
  - Address, data and 32-bit mode held unchanged. `mem_ctrl` redirects to addr+2 internally in this cycle.
  - Next state: LW → CAPT; SW → RESP.
- CAPT:
  - Modes = NONE.
  - Latch `i_cpu_data` (this is the cycle in which `mem_ctrl` presents the data) and extend it:
    - LB: sign from bit 7. LBU: zero-extend [7:0].
    - LH: sign from bit 15. LHU: zero-extend [15:0].
    - LW: unchanged.
  - Next state: RESP.
- RESP: `o_rsp_valid`=1 for exactly one cycle, then IDLE. `o_rsp_rdata`/`o_rsp_err` are held until the next response.
- Mode outputs are registered, and are NONE in every state except ACC1/ACC2.
- Exactly one of `o_wr_mode`/`o_rd_mode` is ever non-NONE.
- `i_req_*` is ignored outside IDLE.
- Reset asserted mid-operation: immediate return to IDLE with modes NONE and no response. A store already in ACC1/ACC2 may be partially written.

## Timing
- Latency is counted from the accepting edge to the `o_rsp_valid` cycle:
  - SB/SH: 2.
  - SW: 3.
  - LB/LBU/LH/LHU: 3.
  - LW: 4.
  - Misaligned: 1.
- Next accept is possible on the edge after RESP.
- Maximum throughput is one request per (latency+1) cycles.
- Back-to-back requests never overlap memory cycles: at least one NONE-mode cycle separates them (CAPT or RESP).
- `i_req_valid` held high with the same request across the RESP cycle is accepted exactly once more on the following IDLE edge. The CPU must deassert it or change it.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - Misalignment is detected as above.
  - Misaligned requests respond with `o_rsp_err`=1 and `o_rsp_rdata`=0.
- `LSU_ALIGN_CHECK_EN` undefined:
  - No check is made. Every request goes to ACC1 with the unmodified address.
  - `o_rsp_err` is tied to 0.
  - Misaligned 16/32-bit results are unspecified.

## Test plan
- Reset, then SW addr 0x010 data 0xDEADBEEF:
  - `o_wr_mode`=2 for exactly 2 cycles starting 1 cycle after accept.
  - `o_rsp_valid` 3 cycles after accept.
  - Memory halfwords 0x010=0xDEAD-order per `mem_ctrl`, 0x012 follows.
- LW addr 0x010 after the store above:
  - `o_rd_mode`=2 for 2 cycles.
  - `o_rsp_rdata`=0xDEADBEEF 4 cycles after accept, `o_rsp_err`=0.
- SB 0x80 at addr 0x021, then LB and LBU at 0x021:
  - LB → 0xFFFFFF80.
  - LBU → 0x00000080.
  - `o_wr_mode`=3 for one cycle.
- LH at 0x023 with `LSU_ALIGN_CHECK_EN`:
  - Response 1 cycle after accept, `o_rsp_err`=1, rdata 0.
  - Modes stay NONE throughout.
  - Without the macro, `o_rd_mode`=1 is issued and err=0.
- `rst` deasserted-to-asserted (low) during ACC2 of an SW:
  - Modes drop to NONE asynchronously.
  - No `o_rsp_valid`; `o_req_ready`=1 on the first cycle after release.
- `i_req_valid` held high with 5 back-to-back LHU requests:
  - `o_req_ready` high only in IDLE.
  - Exactly 5 responses, each 4 cycles apart.
  - No cycle with both modes non-NONE.

Source files
------------

// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Purpose  : Load/store sequencer between the CPU execute stage and mem_ctrl.
//            Accepts one request at a time (valid/ready), drives mem_ctrl's
//            address/data/mode for 1 or 2 cycles, captures and extends load
//            data, and returns a one-cycle response.
// Ports    : clk, rst (async, active-low)
//            i_req_valid/o_req_ready/i_req_op/i_req_addr/i_req_wdata : request
//            o_rsp_valid/o_rsp_rdata/o_rsp_err                       : response
//            o_cpu_addr/o_cpu_data/o_wr_mode/o_rd_mode/i_cpu_data    : mem_ctrl
// Config   : LSU_ALIGN_CHECK_EN - when defined, misaligned 16/32-bit requests
//            skip the memory and respond with o_rsp_err=1, o_rsp_rdata=0.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_ctrl #(
  parameter  int MEM_DEPTH  = 2**12,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH*2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [2:0]            i_req_op,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [31:0]           i_req_wdata,
  output logic                  o_rsp_valid,
  output logic [31:0]           o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic [ADDR_WIDTH-1:0] o_cpu_addr,
  output logic [31:0]           o_cpu_data,
  output logic [1:0]            o_wr_mode,
  output logic [1:0]            o_rd_mode,
  input  logic [31:0]           i_cpu_data
);

  localparam logic [2:0] c_OP_LB  = 3'b000;
  localparam logic [2:0] c_OP_LH  = 3'b001;
  localparam logic [2:0] c_OP_LW  = 3'b010;
  localparam logic [2:0] c_OP_SB  = 3'b011;
  localparam logic [2:0] c_OP_LBU = 3'b100;
  localparam logic [2:0] c_OP_LHU = 3'b101;
  localparam logic [2:0] c_OP_SH  = 3'b110;
  localparam logic [2:0] c_OP_SW  = 3'b111;

  localparam logic [1:0] c_MODE_NONE = 2'd0;
  localparam logic [1:0] c_MODE_W16  = 2'd1;
  localparam logic [1:0] c_MODE_W32  = 2'd2;
  localparam logic [1:0] c_MODE_W8   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACC1 = 3'd1,
    S_ACC2 = 3'd2,
    S_CAPT = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_nxt_state;
  logic [2:0]            r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic [1:0]            r_wr_mode;
  logic [1:0]            r_rd_mode;

  logic [2:0]  w_op;
  logic        w_accept;
  logic        w_is_store;
  logic [1:0]  w_size_mode;
  logic        w_misalign;
  logic [1:0]  w_nxt_wr_mode;
  logic [1:0]  w_nxt_rd_mode;
  logic [31:0] w_ext_data;

  // Ready is gated by rst so it reads 0 while reset is held.
  assign o_req_ready = (r_state == S_IDLE) && rst;
  assign w_accept    = i_req_valid && o_req_ready;
  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_rdata = r_rdata;
  assign o_cpu_addr  = r_addr;
  assign o_cpu_data  = r_wdata;
  assign o_wr_mode   = r_wr_mode;
  assign o_rd_mode   = r_rd_mode;

  // Modes are registered alongside the state, so they are decoded from the
  // next state; in IDLE the op register is not loaded yet, so use the input.
  assign w_op = (r_state == S_IDLE) ? i_req_op : r_op;

  always_comb begin
    w_is_store  = 1'b0;
    w_size_mode = c_MODE_W8;
    case (w_op)
      c_OP_SB:           begin w_is_store = 1'b1; w_size_mode = c_MODE_W8;  end
      c_OP_SH:           begin w_is_store = 1'b1; w_size_mode = c_MODE_W16; end
      c_OP_SW:           begin w_is_store = 1'b1; w_size_mode = c_MODE_W32; end
      c_OP_LH, c_OP_LHU: w_size_mode = c_MODE_W16;
      c_OP_LW:           w_size_mode = c_MODE_W32;
      default:           w_size_mode = c_MODE_W8;
    endcase
  end

`ifdef LSU_ALIGN_CHECK_EN
  logic r_err;
  assign o_rsp_err = r_err;
  always_comb begin
    w_misalign = 1'b0;
    case (i_req_op)
      c_OP_LH, c_OP_LHU, c_OP_SH: w_misalign = i_req_addr[0];
      c_OP_LW, c_OP_SW:           w_misalign = |i_req_addr[1:0];
      default:                    w_misalign = 1'b0;
    endcase
  end
`else
  assign o_rsp_err  = 1'b0;
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_nxt_state = w_misalign ? S_RESP : S_ACC1;
      S_ACC1: begin
        if (w_size_mode == c_MODE_W32) w_nxt_state = S_ACC2;
        else if (w_is_store)           w_nxt_state = S_RESP;
        else                           w_nxt_state = S_CAPT;
      end
      S_ACC2:  w_nxt_state = w_is_store ? S_RESP : S_CAPT;
      S_CAPT:  w_nxt_state = S_RESP;
      S_RESP:  w_nxt_state = S_IDLE;
      default: w_nxt_state = S_IDLE;
    endcase

    w_nxt_wr_mode = c_MODE_NONE;
    w_nxt_rd_mode = c_MODE_NONE;
    if ((w_nxt_state == S_ACC1) || (w_nxt_state == S_ACC2)) begin
      if (w_is_store) w_nxt_wr_mode = w_size_mode;
      else            w_nxt_rd_mode = w_size_mode;
    end
  end

  always_comb begin
    w_ext_data = i_cpu_data;
    case (r_op)
      c_OP_LB:  w_ext_data = {{24{i_cpu_data[7]}}, i_cpu_data[7:0]};
      c_OP_LBU: w_ext_data = {24'd0, i_cpu_data[7:0]};
      c_OP_LH:  w_ext_data = {{16{i_cpu_data[15]}}, i_cpu_data[15:0]};
      c_OP_LHU: w_ext_data = {16'd0, i_cpu_data[15:0]};
      default:  w_ext_data = i_cpu_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_op      <= 3'd0;
      r_addr    <= '0;
      r_wdata   <= 32'd0;
      r_rdata   <= 32'd0;
      r_wr_mode <= c_MODE_NONE;
      r_rd_mode <= c_MODE_NONE;
    end else begin
      r_state   <= w_nxt_state;
      r_wr_mode <= w_nxt_wr_mode;
      r_rd_mode <= w_nxt_rd_mode;
      if (w_accept) begin
        r_op    <= i_req_op;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
      end
      // Response data only changes on the edge entering RESP, so it holds
      // until the next response.
      if (r_state == S_CAPT)
        r_rdata <= w_ext_data;
      else if ((w_nxt_state == S_RESP) && (r_state != S_RESP))
        r_rdata <= 32'd0;
    end
  end

`ifdef LSU_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_err <= 1'b0;
    else if ((w_nxt_state == S_RESP) && (r_state != S_RESP))
      r_err <= (r_state == S_IDLE);
  end
`endif

endmodule
`default_nettype wire
